alu_issue_queue: RTL and testbench

Operand issue stage directly upstream of the 32-bit `ALU`. It buffers `{src1, src2, ALU_control}` requests in a small FIFO and drives the head entry onto the ALU's operand and control ports. It captures the ALU's combinational `result` and `zero`/`cout`/`overflow` flags into a registered output with a valid/ready handshake. It decouples the producer (decoder or pattern sequencer) from the result consumer, so the ALU can be driven back-to-back without stalls.

---
 rtl/alu_issue_queue_if.sv | 49 ++++
 rtl/alu_issue_queue.sv | 169 ++++++++++++++++
 tb/tb_alu_issue_queue.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_queue_if.sv
// alu_issue_queue_if: bundles the three interfaces of the ALU issue stage.
//   Request side:  in_valid/in_ready handshake carrying {in_src1, in_src2, in_op}.
//   ALU side:      alu_src1/alu_src2/alu_ctrl out to the ALU, result and flags back.
//   Result side:   out_valid/out_ready handshake carrying out_result/out_zcv/out_op.
// master: the environment, i.e. the producer, the ALU and the result consumer.
// slave:  the issue queue itself.
interface alu_issue_queue_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 3;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic [OP_W-1:0]   in_op;

  logic [DATA_W-1:0] alu_src1;
  logic [DATA_W-1:0] alu_src2;
  logic [OP_W-1:0]   alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_cout;
  logic              alu_overflow;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [FLAG_W-1:0] out_zcv;
  logic [OP_W-1:0]   out_op;

  modport master (
    output in_valid, in_src1, in_src2, in_op,
    output alu_result, alu_zero, alu_cout, alu_overflow,
    output out_ready,
    input  in_ready,
    input  alu_src1, alu_src2, alu_ctrl,
    input  out_valid, out_result, out_zcv, out_op
  );

  modport slave (
    input  in_valid, in_src1, in_src2, in_op,
    input  alu_result, alu_zero, alu_cout, alu_overflow,
    input  out_ready,
    output in_ready,
    output alu_src1, alu_src2, alu_ctrl,
    output out_valid, out_result, out_zcv, out_op
  );
endinterface

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: operand issue stage in front of the 32-bit ALU.
// Buffers {src1, src2, op} requests in a DEPTH-entry FIFO, drives the head
// entry onto the ALU operand/control ports and captures the ALU's result and
// {zero, cout, overflow} flags into a valid/ready output register.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset, clears all state
//   bus    - alu_issue_queue_if.slave (request, ALU and result signals)
//   count  - FIFO occupancy, 0..DEPTH
//
// Parameters: DEPTH (power of 2, >= 2), PTR_W = log2(DEPTH).
//
// Optional feature, macro ALU_ISSUE_BYPASS_EN: when the FIFO is empty a valid
// request drives the ALU directly and, if the output register is free, is
// captured at the same edge without touching the FIFO.
module alu_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_queue_if.slave bus,
  output logic [PTR_W:0]   count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 3;

  typedef struct packed {
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [OP_W-1:0]   op;
  } entry_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  state_t            state_q;
  state_t            state_d;

  logic [DATA_W-1:0] out_result_q;
  logic [FLAG_W-1:0] out_zcv_q;
  logic [OP_W-1:0]   out_op_q;

  entry_t            in_entry;
  entry_t            head;
  entry_t            drive;
  logic              fifo_empty;
  logic              fifo_full;
  logic              out_valid;
  logic              out_free;
  logic              bypass;
  logic              issue;
  logic              push;
  logic              pop;

  // Status decode from registered state only.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PTR_W+1)'(DEPTH));
  assign out_valid  = (state_q == S_FULL);
  assign out_free   = !out_valid || bus.out_ready;
  assign in_entry   = '{src1: bus.in_src1, src2: bus.in_src2, op: bus.in_op};
  assign head       = mem[rd_ptr];

`ifdef ALU_ISSUE_BYPASS_EN
  assign bypass = fifo_empty && bus.in_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed request that is captured immediately never enters the FIFO.
  assign issue = (!fifo_empty || bypass) && out_free;
  assign pop   = !fifo_empty && issue;
  assign push  = bus.in_valid && !fifo_full && !(bypass && out_free);

  // ALU operand drive: head entry, bypassed request, or zero when idle.
  always_comb begin
    drive = '0;
    if (!fifo_empty) begin
      drive = head;
    end else if (bypass) begin
      drive = in_entry;
    end
  end

  assign bus.alu_src1   = drive.src1;
  assign bus.alu_src2   = drive.src2;
  assign bus.alu_ctrl   = drive.op;
  assign bus.in_ready   = !fifo_full;
  assign bus.out_valid  = out_valid;
  assign bus.out_result = out_result_q;
  assign bus.out_zcv    = out_zcv_q;
  assign bus.out_op     = out_op_q;

  // FIFO storage and pointers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Output register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: issue always fills; a drain with no issue empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (issue) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (issue) begin
          state_d = S_FULL;
        end else if (bus.out_ready) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Result capture; values persist after a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result_q <= '0;
      out_zcv_q    <= '0;
      out_op_q     <= '0;
    end else if (issue) begin
      out_result_q <= bus.alu_result;
      out_zcv_q    <= {bus.alu_zero, bus.alu_cout, bus.alu_overflow};
      out_op_q     <= drive.op;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed self-checking bench for alu_issue_queue.
// Contains a small behavioural ALU so the DUT's ALU ports form a closed loop.
module tb_alu_issue_queue;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

`ifdef ALU_ISSUE_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] count;
  int         checks;
  int         errors;

  alu_issue_queue_if bus ();

  alu_issue_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU.
  logic [32:0] alu_wide;
  logic [31:0] alu_r;
  logic        alu_c;
  logic        alu_v;
  always_comb begin
    alu_wide = '0;
    alu_r    = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (bus.alu_ctrl)
      OP_AND: alu_r = bus.alu_src1 & bus.alu_src2;
      OP_OR:  alu_r = bus.alu_src1 | bus.alu_src2;
      OP_ADD: begin
        alu_wide = {1'b0, bus.alu_src1} + {1'b0, bus.alu_src2};
        alu_r    = alu_wide[31:0];
        alu_c    = alu_wide[32];
        alu_v    = (bus.alu_src1[31] == bus.alu_src2[31]) && (alu_r[31] != bus.alu_src1[31]);
      end
      OP_SUB: begin
        alu_wide = {1'b0, bus.alu_src1} + {1'b0, ~bus.alu_src2} + 33'd1;
        alu_r    = alu_wide[31:0];
        alu_c    = alu_wide[32];
        alu_v    = (bus.alu_src1[31] != bus.alu_src2[31]) && (alu_r[31] != bus.alu_src1[31]);
      end
      default: alu_r = '0;
    endcase
    bus.alu_result   = alu_r;
    bus.alu_zero     = (alu_r == 32'd0);
    bus.alu_cout     = alu_c;
    bus.alu_overflow = alu_v;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got %h exp 0", bus.out_result); end
    checks++; if (bus.out_zcv !== 3'b000) begin errors++; $display("FAIL reset_out_zcv got %b exp 000", bus.out_zcv); end
    checks++; if (bus.out_op !== 4'h0) begin errors++; $display("FAIL reset_out_op got %h exp 0", bus.out_op); end
    checks++; if (bus.alu_src1 !== 32'h0 || bus.alu_src2 !== 32'h0 || bus.alu_ctrl !== 4'h0) begin
      errors++; $display("FAIL reset_alu_drive got %h %h %h exp 0 0 0", bus.alu_src1, bus.alu_src2, bus.alu_ctrl);
    end
    rst = 1'b0;
    step();
  endtask

  // Single requests into an idle queue: latency, result and flag passthrough.
  task automatic test_single_op();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [3:0]  vop [3];
    logic [31:0] vres [3];
    logic [2:0]  vzcv [3];
    logic [31:0] exp_head;
    logic [31:0] head_seen;
    int          lat;
    bit          seen;
    va[0] = 32'h0000_0005; vb[0] = 32'h0000_0003; vop[0] = OP_ADD; vres[0] = 32'h0000_0008; vzcv[0] = 3'b000;
    va[1] = 32'h7FFF_FFFF; vb[1] = 32'h0000_0001; vop[1] = OP_ADD; vres[1] = 32'h8000_0000; vzcv[1] = 3'b001;
    va[2] = 32'h0000_0005; vb[2] = 32'h0000_0005; vop[2] = OP_SUB; vres[2] = 32'h0000_0000; vzcv[2] = 3'b110;
    for (int t = 0; t < 3; t++) begin
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_src1   = va[t];
      bus.in_src2   = vb[t];
      bus.in_op     = vop[t];
      lat       = 0;
      seen      = 1'b0;
      head_seen = 32'hDEAD_BEEF;
      for (int k = 0; k < 8 && !seen; k++) begin
        step();
        lat++;
        bus.in_valid = 1'b0;
        if (lat == 1) head_seen = bus.alu_src1;
        if (bus.out_valid) seen = 1'b1;
      end
      exp_head = (EXP_LAT == 2) ? va[t] : 32'h0;
      checks++; if (!seen || lat != EXP_LAT) begin errors++; $display("FAIL single_latency[%0d] got %0d exp %0d", t, lat, EXP_LAT); end
      checks++; if (head_seen !== exp_head) begin errors++; $display("FAIL single_head[%0d] got %h exp %h", t, head_seen, exp_head); end
      checks++; if (bus.out_result !== vres[t]) begin errors++; $display("FAIL single_result[%0d] got %h exp %h", t, bus.out_result, vres[t]); end
      checks++; if (bus.out_zcv !== vzcv[t]) begin errors++; $display("FAIL single_zcv[%0d] got %b exp %b", t, bus.out_zcv, vzcv[t]); end
      checks++; if (bus.out_op !== vop[t]) begin errors++; $display("FAIL single_op[%0d] got %h exp %h", t, bus.out_op, vop[t]); end
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain[%0d] got %b exp 0", t, bus.out_valid); end
      checks++; if (bus.out_result !== vres[t]) begin errors++; $display("FAIL single_hold[%0d] got %h exp %h", t, bus.out_result, vres[t]); end
      checks++; if (bus.alu_src1 !== 32'h0 || bus.alu_ctrl !== 4'h0) begin
        errors++; $display("FAIL single_idle_drive[%0d] got %h %h exp 0 0", t, bus.alu_src1, bus.alu_ctrl);
      end
    end
  endtask

  // Five pushes under backpressure, an ignored sixth, then in-order release.
  task automatic test_fill_backpressure();
    logic [31:0] exp_res;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_src1  = 32'h100 + 32'(i);
      bus.in_src2  = 32'h1000;
      bus.in_op    = OP_ADD;
      step();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b exp 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h1100) begin
      errors++; $display("FAIL fill_first got %b %h exp 1 00001100", bus.out_valid, bus.out_result);
    end
    bus.in_src1 = 32'h5555_5555;
    step();
    step();
    bus.in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ignored_push_count got %0d exp 4", count); end
    checks++; if (bus.out_result !== 32'h1100) begin errors++; $display("FAIL backpressure_hold got %h exp 00001100", bus.out_result); end
    checks++; if (bus.alu_src1 !== 32'h101) begin errors++; $display("FAIL backpressure_head got %h exp 00000101", bus.alu_src1); end
    for (int i = 0; i < 5; i++) begin
      exp_res = 32'h1100 + 32'(i);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== exp_res) begin
        errors++; $display("FAIL release[%0d] got %b %h exp 1 %h", i, bus.out_valid, bus.out_result, exp_res);
      end
      bus.out_ready = 1'b1;
      step();
    end
    checks++; if (bus.out_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL release_end got %b %0d exp 0 0", bus.out_valid, count);
    end
  endtask

  // 30 requests streamed while the consumer toggles ready every 3 cycles.
  task automatic test_wrap_around();
    int          tx;
    int          rx;
    bit          acc;
    logic [31:0] exp_res;
    tx = 0;
    rx = 0;
    for (int cyc = 0; cyc < 400 && rx < 30; cyc++) begin
      bus.out_ready = (((cyc / 3) % 2) == 0);
      if (tx < 30) begin
        bus.in_valid = 1'b1;
        bus.in_src1  = 32'(tx) * 32'd8 + 32'd3;
        bus.in_src2  = 32'(tx);
        bus.in_op    = OP_SUB;
      end else begin
        bus.in_valid = 1'b0;
      end
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        exp_res = 32'(rx) * 32'd7 + 32'd3;
        checks++; if (bus.out_result !== exp_res || bus.out_op !== OP_SUB) begin
          errors++; $display("FAIL wrap_result[%0d] got %h op %h exp %h op %h", rx, bus.out_result, bus.out_op, exp_res, OP_SUB);
        end
        rx++;
      end
      step();
      if (acc) tx++;
    end
    bus.in_valid = 1'b0;
    checks++; if (rx != 30 || tx != 30) begin errors++; $display("FAIL wrap_total got rx %0d tx %0d exp 30 30", rx, tx); end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL wrap_extra got %b %0d exp 0 0", bus.out_valid, count);
    end
  endtask

  // Asynchronous reset with entries queued and a result held.
  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_src1  = 32'h20 + 32'(i);
      bus.in_src2  = 32'h1;
      bus.in_op    = OP_OR;
      step();
    end
    bus.in_valid = 1'b0;
    checks++; if (count !== 3'd3 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_setup got %0d %b exp 3 1", count, bus.out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_reset_count got %0d exp 0", count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_result !== 32'h0) begin errors++; $display("FAIL mid_reset_out_result got %h exp 0", bus.out_result); end
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.out_valid !== 1'b0 || count !== 3'd0) begin
        errors++; $display("FAIL mid_reset_quiet[%0d] got %b %0d exp 0 0", i, bus.out_valid, count);
      end
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_op();
    test_fill_backpressure();
    test_wrap_around();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
